// File: rtl/pwm_pkg.sv
// pwm_gen_mc shared types: channel mode encoding and index-width helper.
// Optional dead-time stage is selected by the PWM_DEADTIME_EN macro.
package pwm_pkg;

    typedef enum logic [1:0] {
        PWM_LEFT    = 2'b00,
        PWM_RIGHT   = 2'b01,
        PWM_WIN     = 2'b10,
        PWM_WIN_INV = 2'b11
    } pwm_mode_t;

    // Channel-index width: at least one bit even for a single channel
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: working config registers, compare logic, output flop.
// Working config loads only on the commit transfer strobe.
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  pwm_mode_t    i_mode,
    input  logic [W-1:0] i_cmp1,
    input  logic [W-1:0] i_cmp2,
    input  logic [W-1:0] i_count,
    output logic         o_pwm
);

    typedef struct packed {
        logic         en;
        pwm_mode_t    mode;
        logic [W-1:0] cmp1;
        logic [W-1:0] cmp2;
    } cfg_t;

    cfg_t r_cfg;
    logic r_pwm;
    logic w_lo;
    logic w_in;
    logic w_lvl;

    // Working registers take the staged values at the transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg <= cfg_t'('0);
        end else if (i_load) begin
            r_cfg.en   <= i_en;
            r_cfg.mode <= i_mode;
            r_cfg.cmp1 <= i_cmp1;
            r_cfg.cmp2 <= i_cmp2;
        end
    end

    // A reversed window (cmp1 > cmp2) is naturally empty here
    assign w_lo = (i_count >= r_cfg.cmp1);
    assign w_in = w_lo && (i_count < r_cfg.cmp2);

    // Level for the current count; equal compares force low
    always_comb begin
        w_lvl = 1'b0;
        if (r_cfg.en && (r_cfg.cmp1 != r_cfg.cmp2)) begin
            unique case (r_cfg.mode)
                PWM_LEFT:    w_lvl = ~w_lo;
                PWM_RIGHT:   w_lvl = w_lo;
                PWM_WIN:     w_lvl = w_in;
                PWM_WIN_INV: w_lvl = ~w_in;
                default:     w_lvl = 1'b0;
            endcase
        end
    end

    // Registered output, one cycle behind count
    always_ff @(posedge clk) begin
        if (rst) r_pwm <= 1'b0;
        else     r_pwm <= w_lvl;
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary output pair with a dead-time gap after each raw edge.
// Only instantiated when PWM_DEADTIME_EN is defined.
module pwm_deadtime #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_raw,
    input  logic [DT_W-1:0] i_dt,
    output logic            o_p,
    output logic            o_n
);

    logic            r_prev;
    logic [DT_W-1:0] r_cnt;
    logic            r_p;
    logic            r_n;

    // Each raw edge restarts the gap; a short pulse keeps both sides low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
            r_p    <= 1'b0;
            r_n    <= 1'b0;
        end else begin
            r_prev <= i_raw;
            if (i_raw != r_prev) begin
                r_cnt <= i_dt;
                r_p   <= (i_dt == '0) &&  i_raw;
                r_n   <= (i_dt == '0) && !i_raw;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
                r_p   <= (r_cnt == 1) &&  i_raw;
                r_n   <= (r_cnt == 1) && !i_raw;
            end else begin
                r_p <=  i_raw;
                r_n <= !i_raw;
            end
        end
    end

    assign o_p = r_p;
    assign o_n = r_n;

endmodule

// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM: shared period counter, staged config, boundary commit.
// Define PWM_DEADTIME_EN to add complementary outputs with dead time.
module pwm_gen_mc
    import pwm_pkg::*;
#(
    parameter int CH = 4,
    parameter int W  = 16,
`ifdef PWM_DEADTIME_EN
    parameter int DT_W = 8,
`endif
    localparam int CHW = idx_w(CH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cnt_en,
    input  logic           cfg_wr,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [1:0]     cfg_mode,
    input  logic           cfg_en,
    input  logic [W-1:0]   cfg_cmp1,
    input  logic [W-1:0]   cfg_cmp2,
    input  logic           per_wr,
    input  logic [W-1:0]   per_val,
    input  logic           commit,
    output logic           commit_pend,
    output logic           period_done,
    output logic [W-1:0]   count_val,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_W-1:0] dead_time,
    output logic [CH-1:0]  pwm_out_n,
`endif
    output logic [CH-1:0]  pwm_out
);

    typedef struct packed {
        logic         en;
        pwm_mode_t    mode;
        logic [W-1:0] cmp1;
        logic [W-1:0] cmp2;
    } cfg_t;

    cfg_t          r_stg [CH];
    logic [W-1:0]  r_per_s;
    logic [W-1:0]  r_per_w;
    logic [W-1:0]  r_count;
    logic          r_done;
    logic          r_pend;
    logic          r_pulse;
    logic          w_ch_ok;
    logic          w_wrap;
    logic          w_bnd;
    logic          w_req;
    logic          w_xfer;
    logic [CH-1:0] w_raw;

    assign w_ch_ok = (32'(cfg_ch) < 32'(CH));
    assign w_wrap  = (r_count == r_per_w);
    assign w_bnd   = !cnt_en || w_wrap;
    assign w_req   = r_pend || commit;
    assign w_xfer  = w_req && w_bnd;

    // Staging writes; they only reach outputs through a commit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) r_stg[i] <= cfg_t'('0);
            r_per_s <= '0;
        end else begin
            if (cfg_wr && w_ch_ok) begin
                r_stg[cfg_ch].en   <= cfg_en;
                r_stg[cfg_ch].mode <= pwm_mode_t'(cfg_mode);
                r_stg[cfg_ch].cmp1 <= cfg_cmp1;
                r_stg[cfg_ch].cmp2 <= cfg_cmp2;
            end
            if (per_wr) r_per_s <= per_val;
        end
    end

    // Counter, wrap pulse, and commit handshake with period transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_done  <= 1'b0;
            r_per_w <= '0;
            r_pend  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            if (cnt_en) r_count <= w_wrap ? '0 : r_count + 1'b1;
            r_done  <= cnt_en && w_wrap;
            if (w_xfer) r_per_w <= r_per_s;
            r_pend  <= w_req && !w_xfer;
            r_pulse <= commit && w_xfer && !r_pend;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_chan
        pwm_chan #(.W(W)) u_chan (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_xfer),
            .i_en   (r_stg[g].en),
            .i_mode (r_stg[g].mode),
            .i_cmp1 (r_stg[g].cmp1),
            .i_cmp2 (r_stg[g].cmp2),
            .i_count(r_count),
            .o_pwm  (w_raw[g])
        );
    end

`ifdef PWM_DEADTIME_EN
    for (genvar g = 0; g < CH; g++) begin : g_dt
        pwm_deadtime #(.DT_W(DT_W)) u_dt (
            .clk  (clk),
            .rst  (rst),
            .i_raw(w_raw[g]),
            .i_dt (dead_time),
            .o_p  (pwm_out[g]),
            .o_n  (pwm_out_n[g])
        );
    end
`else
    assign pwm_out = w_raw;
`endif

    assign commit_pend = r_pend || r_pulse;
    assign period_done = r_done;
    assign count_val   = r_count;

endmodule

// File: tb/tb_pwm_gen_mc.sv
// Scoreboard bench for pwm_gen_mc: model predicts, monitor compares.
// Directed scenarios followed by a randomized run.
module tb_pwm_gen_mc;

    localparam int CH  = 4;
    localparam int W   = 16;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           cnt_en;
    logic           cfg_wr;
    logic [CHW-1:0] cfg_ch;
    logic [1:0]     cfg_mode;
    logic           cfg_en;
    logic [W-1:0]   cfg_cmp1;
    logic [W-1:0]   cfg_cmp2;
    logic           per_wr;
    logic [W-1:0]   per_val;
    logic           commit;
    logic           commit_pend;
    logic           period_done;
    logic [W-1:0]   count_val;
    logic [CH-1:0]  pwm_out;
`ifdef PWM_DEADTIME_EN
    logic [7:0]     dead_time = 8'd0;
    logic [CH-1:0]  pwm_out_n;
`endif

    always #5 clk = ~clk;

    pwm_gen_mc #(.CH(CH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_en     (cnt_en),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_en     (cfg_en),
        .cfg_cmp1   (cfg_cmp1),
        .cfg_cmp2   (cfg_cmp2),
        .per_wr     (per_wr),
        .per_val    (per_val),
        .commit     (commit),
        .commit_pend(commit_pend),
        .period_done(period_done),
        .count_val  (count_val),
`ifdef PWM_DEADTIME_EN
        .dead_time  (dead_time),
        .pwm_out_n  (pwm_out_n),
`endif
        .pwm_out    (pwm_out)
    );

    typedef struct {
        logic [W-1:0]  cnt;
        bit            done;
        bit            pend;
        bit [CH-1:0]   pwm;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // reference state: plain integers and arrays
    int m_cnt, m_per_w, m_per_s;
    int s_en[CH], s_md[CH], s_c1[CH], s_c2[CH];
    int w_en[CH], w_md[CH], w_c1[CH], w_c2[CH];
    bit m_pend, m_pulse, m_done;
    bit [CH-1:0] m_out, m_out_d;

    function automatic bit lvl(int en, int md, int c1, int c2, int x);
        bit inwin;
        if (en == 0 || c1 == c2) return 1'b0;
        inwin = (x >= c1) && (x < c2);
        case (md)
            0:       return x < c1;
            1:       return x >= c1;
            2:       return inwin;
            default: return !inwin;
        endcase
    endfunction

    // model: advance one clock using the inputs present at this edge
    always @(posedge clk) begin
        exp_t e;
        bit bnd, req, xfer;
        bit [CH-1:0] nout;
        if (rst) begin
            m_cnt = 0; m_per_w = 0; m_per_s = 0;
            m_pend = 0; m_pulse = 0; m_done = 0;
            m_out = '0; m_out_d = '0;
            for (int i = 0; i < CH; i++) begin
                s_en[i] = 0; s_md[i] = 0; s_c1[i] = 0; s_c2[i] = 0;
                w_en[i] = 0; w_md[i] = 0; w_c1[i] = 0; w_c2[i] = 0;
            end
        end else begin
            for (int i = 0; i < CH; i++)
                nout[i] = lvl(w_en[i], w_md[i], w_c1[i], w_c2[i], m_cnt);
            bnd  = !cnt_en || (m_cnt == m_per_w);
            req  = m_pend || commit;
            xfer = req && bnd;
            m_done = cnt_en && (m_cnt == m_per_w);
            if (cnt_en) m_cnt = (m_cnt == m_per_w) ? 0 : m_cnt + 1;
            m_pulse = commit && xfer && !m_pend;
            m_pend  = req && !xfer;
            if (xfer) begin
                m_per_w = m_per_s;
                for (int i = 0; i < CH; i++) begin
                    w_en[i] = s_en[i]; w_md[i] = s_md[i];
                    w_c1[i] = s_c1[i]; w_c2[i] = s_c2[i];
                end
            end
            if (cfg_wr && int'(cfg_ch) < CH) begin
                s_en[cfg_ch] = int'(cfg_en);
                s_md[cfg_ch] = int'(cfg_mode);
                s_c1[cfg_ch] = int'(cfg_cmp1);
                s_c2[cfg_ch] = int'(cfg_cmp2);
            end
            if (per_wr) m_per_s = int'(per_val);
            m_out_d = m_out;
            m_out   = nout;
        end
        e.cnt  = m_cnt[W-1:0];
        e.done = m_done;
        e.pend = m_pend || m_pulse;
`ifdef PWM_DEADTIME_EN
        e.pwm  = m_out_d;
`else
        e.pwm  = m_out;
`endif
        sb.push_back(e);
    end

    // monitor: compare DUT outputs against the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk += 4;
            if (count_val !== e.cnt) begin
                n_fail++;
                $display("FAIL count_val t=%0t got %0d want %0d", $time, count_val, e.cnt);
            end
            if (period_done !== e.done) begin
                n_fail++;
                $display("FAIL period_done t=%0t got %b want %b", $time, period_done, e.done);
            end
            if (commit_pend !== e.pend) begin
                n_fail++;
                $display("FAIL commit_pend t=%0t got %b want %b", $time, commit_pend, e.pend);
            end
            if (pwm_out !== e.pwm) begin
                n_fail++;
                $display("FAIL pwm_out t=%0t got %b want %b", $time, pwm_out, e.pwm);
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_cfg(int ch, int md, int en, int c1, int c2);
        cfg_wr   = 1'b1;
        cfg_ch   = ch[CHW-1:0];
        cfg_mode = md[1:0];
        cfg_en   = en[0];
        cfg_cmp1 = c1[W-1:0];
        cfg_cmp2 = c2[W-1:0];
        step(1);
        cfg_wr = 1'b0;
    endtask

    task automatic wr_per(int p);
        per_wr  = 1'b1;
        per_val = p[W-1:0];
        step(1);
        per_wr = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step(1);
        commit = 1'b0;
    endtask

    task automatic wait_cnt(int v);
        for (int i = 0; i < 200 && m_cnt != v; i++) step(1);
    endtask

    int rc1, rc2;

    initial begin
        rst = 1'b1; cnt_en = 1'b0; cfg_wr = 1'b0; cfg_ch = '0;
        cfg_mode = '0; cfg_en = 1'b0; cfg_cmp1 = '0; cfg_cmp2 = '0;
        per_wr = 1'b0; per_val = '0; commit = 1'b0;
        step(3);
        rst = 1'b0;
        step(2);

        // left mode on ch0, committed while the counter is stopped
        wr_cfg(0, 0, 1, 3, 0);
        wr_per(9);
        do_commit();
        cnt_en = 1'b1;
        step(25);

        // window and inverted window, committed mid-period
        wr_cfg(1, 2, 1, 2, 6);
        wr_cfg(2, 3, 1, 2, 6);
        do_commit();
        step(25);

        // equal compares force both low
        wr_cfg(1, 2, 1, 4, 4);
        wr_cfg(2, 3, 1, 4, 4);
        do_commit();
        step(25);

        // width change requested at count 5 lands at the wrap
        wait_cnt(4);
        wr_cfg(0, 0, 1, 7, 0);
        do_commit();
        do_commit();
        step(25);

        // commit in the very boundary cycle
        wr_cfg(3, 1, 1, 6, 0);
        wait_cnt(9);
        do_commit();
        step(12);

        // period zero
        wr_per(0);
        do_commit();
        step(10);

        // frozen counter: commit applies next cycle
        cnt_en = 1'b0;
        wr_per(9);
        do_commit();
        step(5);
        cnt_en = 1'b1;
        step(5);

        // reset with a commit still pending
        wait_cnt(3);
        wr_per(4);
        do_commit();
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(10);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(0, 499) == 0);
            cnt_en = ($urandom_range(0, 9) != 0);
            commit = ($urandom_range(0, 9) == 0);
            per_wr = ($urandom_range(0, 19) == 0);
            per_val = ($urandom_range(0, 9) == 0) ? W'(0) : W'($urandom_range(1, 12));
            cfg_wr = ($urandom_range(0, 4) == 0);
            cfg_ch = CHW'($urandom_range(0, CH - 1));
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_en = ($urandom_range(0, 3) != 0);
            rc1 = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 65535))
                                               : int'($urandom_range(0, 14));
            rc2 = int'($urandom_range(0, 14));
            cfg_cmp1 = rc1[W-1:0];
            cfg_cmp2 = rc2[W-1:0];
            step(1);
        end
        rst = 1'b0; cfg_wr = 1'b0; per_wr = 1'b0; commit = 1'b0;
        step(3);
        @(negedge clk);
        #1;

        n_chk++;
        if (sb.size() > 1) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries want at most 1", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
